// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the sequential chunked add/subtract unit:
// FSM state encoding and the WIDTH/CHUNK parameter legality check.
// Optional feature macro used by the files of this block: SEQ_CHUNK_ADDER_OVF_EN
// (adds the signed-overflow output).
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when CHUNK is a usable slice width for WIDTH-bit operands.
  function automatic bit params_legal(input int unsigned width, input int unsigned chunk);
    if (chunk == 0) return 1'b0;
    if (chunk > width) return 1'b0;
    return (width % chunk) == 0;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit full adder shared by every slice.
// Ports:
//   a, b      - CHUNK-bit slice operands
//   cin       - carry into bit 0
//   s         - CHUNK-bit slice sum
//   carry     - carry out of the slice MSB
//   carry_msb - carry into the slice MSB (only with SEQ_CHUNK_ADDER_OVF_EN)
module chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             carry
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,
  output logic             carry_msb
`endif
);

  logic [CHUNK:0] sum_w;

  // One extra bit on the sum captures the slice carry-out.
  always_comb begin
    sum_w = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

  assign s     = sum_w[CHUNK-1:0];
  assign carry = sum_w[CHUNK];

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
  assign carry_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum_w[CHUNK-1];
`endif

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit add/subtract built around one shared
// CHUNK-bit adder. One slice is added per clock with the carry registered
// between slices; valid/ready handshake on both sides, no overlap of operations.
// Optional feature macro: SEQ_CHUNK_ADDER_OVF_EN adds the ovf output.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - operand handshake (accepted only in IDLE)
//   a, b, cin, sub      - operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready - result handshake (result held in DONE)
//   s, carry            - result and MSB carry-out (carry=1 means no borrow on sub)
//   ovf                 - signed overflow (only with SEQ_CHUNK_ADDER_OVF_EN)
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Elaboration-time guard on the slice geometry.
  if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // holds ~b for subtraction
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cy_q, cy_d;    // inter-slice carry, final value is the MSB carry-out
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [CHUNK-1:0]   a_sl;
  logic [CHUNK-1:0]   b_sl;
  logic [CHUNK-1:0]   sum_sl;
  logic               cout_sl;

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
  logic               cmsb_sl;
`endif

  // Select the operand slices addressed by the chunk index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a         (a_sl),
    .b         (b_sl),
    .cin       (cy_q),
    .s         (sum_sl),
    .carry     (cout_sl)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    .carry_msb (cmsb_sl)
`endif
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cy_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      cy_q        <= cy_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    cy_d        = cy_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          b_d        = sub ? ~b : b;
          cy_d       = sub ? 1'b1 : cin;
          idx_d      = '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
        end
      end

      BUSY: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDX_W'(i)) begin
            s_d[i*CHUNK +: CHUNK] = sum_sl;
          end
        end
        cy_d = cout_sl;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
          ovf_d       = cmsb_sl ^ cout_sl;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign carry     = cy_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: a 64/16 instance (four slices) and a 64/64
// instance (single slice), table-driven vectors plus hand-written sequences
// for reset, back-pressure and abort-during-BUSY.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, carry;
  logic [63:0] s;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready1, out_valid1, carry1;
  logic [63:0] s1;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic        ovf, ovf1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .carry(carry)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  seq_chunk_adder #(.WIDTH(64), .CHUNK(64)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready1), .s(s1), .carry(carry1)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue one operation to dut (sel=0) or dut1 (sel=1), wait for the result,
  // capture it and complete the output handshake. lat counts edges after accept.
  task automatic run_op(input bit sel, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic tc, input logic ts,
                        output logic [63:0] rs, output logic rc, output logic ro,
                        output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", 64'(sel ? in_ready1 : in_ready), 64'd1);
    a = ta; b = tb_v; cin = tc; sub = ts;
    if (sel) in_valid1 = 1'b1; else in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_valid1 = 1'b0;
    lat = 0;
    while (!(sel ? out_valid1 : out_valid) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rs = sel ? s1 : s;
    rc = sel ? carry1 : carry;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ro = sel ? ovf1 : ovf;
`else
    ro = 1'b0;
`endif
    if (sel) out_ready1 = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready1 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] rs, s_hold;
    logic        rc, ro, c_hold;
    int          lat, seen;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1]  = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{64'h3, 64'h4, 1'b1, 1'b0, 64'h8, 1'b0, 1'b0};
    vecs[3]  = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[4]  = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6]  = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[7]  = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                 64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
    vecs[9]  = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                 64'h0001_0000_0001_0000, 1'b0, 1'b0};
    vecs[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    chk("por_s", s, 64'h0);
    chk("por_carry", 64'(carry), 64'd0);
    chk("por_out_valid", 64'(out_valid), 64'd0);
    chk("por_out_valid1", 64'(out_valid1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("por_in_ready", 64'(in_ready), 64'd1);
    chk("por_in_ready1", 64'(in_ready1), 64'd1);

    // Table-driven vectors on both slice geometries.
    for (int i = 0; i < 11; i++) begin
      for (int sel = 0; sel < 2; sel++) begin
        run_op(sel[0], vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
        chk($sformatf("vec%0d_dut%0d_s", i, sel), rs, vecs[i].s);
        chk($sformatf("vec%0d_dut%0d_carry", i, sel), 64'(rc), 64'(vecs[i].c));
        chk($sformatf("vec%0d_dut%0d_latency", i, sel), 64'(lat), (sel == 1) ? 64'd1 : 64'd4);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        chk($sformatf("vec%0d_dut%0d_ovf", i, sel), 64'(ro), 64'(vecs[i].o));
`endif
        chk($sformatf("vec%0d_dut%0d_valid_drop", i, sel),
            64'(sel == 1 ? out_valid1 : out_valid), 64'd0);
      end
    end

    // Asynchronous reset between clock edges while holding a result in DONE.
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("async_pre_s", s, 64'h1);
    chk("async_pre_carry", 64'(carry), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_s", s, 64'h0);
    chk("async_carry", 64'(carry), 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    #1 rst = 1'b0;
    #1;
    chk("async_in_ready", 64'(in_ready), 64'd1);

    // Back-pressure: result held, new request ignored until handshake.
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("bp_first_latency", 64'(lat), 64'd4);
    s_hold = s; c_hold = carry;
    chk("bp_first_s", s_hold, 64'h0);
    chk("bp_first_carry", 64'(c_hold), 64'd1);
    a = 64'h3; b = 64'h4; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_s", k), s, 64'h0);
      chk($sformatf("bp_hold%0d_carry", k), 64'(carry), 64'd1);
      chk($sformatf("bp_hold%0d_out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("bp_second_latency", 64'(lat), 64'd4);
    chk("bp_second_s", s, 64'h8);
    chk("bp_second_carry", 64'(carry), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset two cycles after accept aborts the operation.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_s", s, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_out_valid", 64'(seen), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    run_op(1'b0, 64'h3, 64'h4, 1'b1, 1'b0, rs, rc, ro, lat);
    chk("after_abort_s", rs, 64'h8);
    chk("after_abort_carry", 64'(rc), 64'd0);
    chk("after_abort_latency", 64'(lat), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
